// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide sequencing controller.
// Launches a compute op, holds busy for a fixed per-class latency, then
// commits the pending result into HI/LO. Also serves mfhi/mflo reads and
// mthi/mtlo writes. Launches and moves are dropped while the CP0 request
// (req) is flushing the E-stage instruction.
// Optional feature macro: MDU_MADD_EN enables madd/maddu/msub/msubu (ops 9-12).
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        req,
  output logic        start,
  output logic        busy,
  output logic [31:0] mduo,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  logic [0:0]  state_q, state_d;
  logic        busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_compute;
  logic        is_div;
  logic [63:0] prod_s, prod_u;
  logic [63:0] result;
  logic [31:0] mag_a, mag_b, q_mag, r_mag;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;

  // Classify the E-stage op and derive the launch strobe.
  always_comb begin
    is_compute = 1'b0;
    is_div     = 1'b0;
    case (op)
      OP_MULT, OP_MULTU: is_compute = 1'b1;
      OP_DIV, OP_DIVU: begin
        is_compute = 1'b1;
        is_div     = 1'b1;
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_compute = 1'b1;
`endif
      default: ;
    endcase
    start = is_compute & ~busy_q & ~req;
  end

  // Arithmetic datapath: 64-bit products and sign-magnitude division.
  // Division goes through magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // instead of relying on simulator overflow behaviour.
  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
    mag_a  = a[31] ? (~a + 32'd1) : a;
    mag_b  = b[31] ? (~b + 32'd1) : b;
    q_mag  = (b == 32'd0) ? 32'd0 : mag_a / mag_b;
    r_mag  = (b == 32'd0) ? 32'd0 : mag_a % mag_b;
    quot_s = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
    rem_s  = a[31] ? (~r_mag + 32'd1) : r_mag;
    quot_u = (b == 32'd0) ? 32'd0 : a / b;
    rem_u  = (b == 32'd0) ? 32'd0 : a % b;

    // Divide by zero re-commits the current HI/LO, leaving them unchanged.
    result = {hi_q, lo_q};
    case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   if (b != 32'd0) result = {rem_s, quot_s};
      OP_DIVU:  if (b != 32'd0) result = {rem_u, quot_u};
`ifdef MDU_MADD_EN
      OP_MADD:  result = {hi_q, lo_q} + prod_s;
      OP_MADDU: result = {hi_q, lo_q} + prod_u;
      OP_MSUB:  result = {hi_q, lo_q} - prod_s;
      OP_MSUBU: result = {hi_q, lo_q} - prod_u;
`endif
      default: ;
    endcase
  end

  // Next-state logic: launch, countdown, commit and mthi/mtlo writes.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          {phi_d, plo_d} = result;
          cnt_d          = is_div ? DIV_LAT : MULT_LAT;
          busy_d         = 1'b1;
          state_d        = S_BUSY;
        end else if (!req && op == OP_MTHI) begin
          hi_d = a;
        end else if (!req && op == OP_MTLO) begin
          lo_d = a;
        end
      end
      default: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State registers with synchronous reset that discards any pending result.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= 4'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Read port and architectural outputs.
  always_comb begin
    mduo = 32'd0;
    if (op == OP_MFHI)      mduo = hi_q;
    else if (op == OP_MFLO) mduo = lo_q;
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl.
// Build with +define+MDU_MADD_EN to exercise the multiply-accumulate ops.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        req;
  logic        start, busy;
  logic [31:0] mduo, hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .a     (a),
    .b     (b),
    .req   (req),
    .start (start),
    .busy  (busy),
    .mduo  (mduo),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                       input logic r);
    op  = o;
    a   = va;
    b   = vb;
    req = r;
    #1;
  endtask

  // Count cycles busy stays high (bounded), then check the expected latency.
  task automatic wait_done(input string tag, input int lat);
    int n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    check(tag, 32'(n), 32'(lat));
  endtask

  initial begin
    reset = 1'b1;
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    // 1: signed mult -3 * 5
    drive(4'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    check("mult_start", {31'd0, start}, 32'd1);
    tick();
    check("mult_start_drops", {31'd0, start}, 32'd0);
    check("mult_busy", {31'd0, busy}, 32'd1);
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    wait_done("mult_lat", 5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);

    // multu of the same operands
    drive(4'd2, 32'hFFFF_FFFD, 32'd5, 1'b0);
    tick();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    wait_done("multu_lat", 5);
    check("multu_hi", hi, 32'd4);
    check("multu_lo", lo, 32'hFFFF_FFF1);

    // 2: divu then signed div; also compute op ignored while busy
    drive(4'd4, 32'd100, 32'd7, 1'b0);
    tick();
    drive(4'd1, 32'd9, 32'd9, 1'b0);
    check("busy_ignores_start", {31'd0, start}, 32'd0);
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    wait_done("divu_lat", 10);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    drive(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    tick();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    wait_done("div_lat", 10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    drive(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    tick();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    wait_done("div_ovf_lat", 10);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'd0);

    // 3: mthi/mtlo, divide by zero keeps HI/LO, mf reads
    drive(4'd7, 32'h11, 32'd0, 1'b0);
    tick();
    drive(4'd8, 32'h22, 32'd0, 1'b0);
    tick();
    check("mthi", hi, 32'h11);
    check("mtlo", lo, 32'h22);
    drive(4'd3, 32'd1234, 32'd0, 1'b0);
    tick();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    wait_done("div0_lat", 10);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);
    drive(4'd6, 32'd0, 32'd0, 1'b0);
    check("mflo", mduo, 32'h22);
    drive(4'd5, 32'd0, 32'd0, 1'b0);
    check("mfhi", mduo, 32'h11);
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    check("mduo_none", mduo, 32'd0);

    // 4: req suppresses launch and moves
    drive(4'd1, 32'd3, 32'd3, 1'b1);
    check("req_start", {31'd0, start}, 32'd0);
    tick();
    check("req_busy", {31'd0, busy}, 32'd0);
    check("req_lo", lo, 32'h22);
    drive(4'd7, 32'hABCD, 32'd0, 1'b1);
    tick();
    check("req_mthi", hi, 32'h11);
    drive(4'd7, 32'hABCD, 32'd0, 1'b0);
    tick();
    check("mthi_abcd", hi, 32'hABCD);

    // 5: reset mid-operation, then back-to-back launch
    drive(4'd1, 32'd2, 32'd3, 1'b0);
    tick();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    repeat (6) tick();
    check("rst_no_commit_lo", lo, 32'd0);

    drive(4'd1, 32'd2, 32'd3, 1'b0);
    tick();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    wait_done("b2b_first_lat", 5);
    check("b2b_first_lo", lo, 32'd6);
    drive(4'd1, 32'd4, 32'd5, 1'b0);
    check("b2b_start", {31'd0, start}, 32'd1);
    tick();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    wait_done("b2b_second_lat", 5);
    check("b2b_second_lo", lo, 32'd20);
    check("b2b_second_hi", hi, 32'd0);

    // 6: multiply-accumulate
    drive(4'd7, 32'd0, 32'd0, 1'b0);
    tick();
    drive(4'd8, 32'hFFFF_FFFF, 32'd0, 1'b0);
    tick();
    drive(4'd9, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
    check("madd_start", {31'd0, start}, 32'd1);
    tick();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    wait_done("madd_lat", 5);
    check("madd_hi", hi, 32'd1);
    check("madd_lo", lo, 32'd0);
    drive(4'd11, 32'd2, 32'd3, 1'b0);
    tick();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    wait_done("msub_lat", 5);
    check("msub_hi", hi, 32'd0);
    check("msub_lo", lo, 32'hFFFF_FFFA);
`else
    check("madd_off_start", {31'd0, start}, 32'd0);
    tick();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    check("madd_off_busy", {31'd0, busy}, 32'd0);
    check("madd_off_hi", hi, 32'd0);
    check("madd_off_lo", lo, 32'hFFFF_FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Sequencing controller for the E-stage multiply/divide unit. It accepts a decoded MDU operation with forwarded operands, launches it, and holds busy for a fixed per-class latency. On completion it commits HI/LO and serves mfhi/mflo reads. It drops new launches when the CP0 interrupt/exception request is asserted, so a flushed instruction never modifies HI/LO. Its start/busy outputs feed the stall unit.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (and madd family when enabled); legal range 1..15
DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
op  input  4  E-stage MDU op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu; 13-15 none
a  input  32  forwarded rs value
b  input  32  forwarded rt value
req  input  1  CP0 exception/interrupt request; high means the E-stage instruction is being flushed
start  output  1  combinational; a compute op is launched this cycle
busy  output  1  registered; a compute op is in flight
mduo  output  32  combinational read data: hi for mfhi, lo for mflo, else 0
hi  output  32  architectural HI register
lo  output  32  architectural LO register

Behaviour:
- Reset: state=IDLE, busy=0, cnt=0, hi=0, lo=0, pending result=0. Reset overrides every other input, including mid-operation; the pending result is discarded.
- Compute ops are 1-4, plus 9-12 when the optional feature is enabled.
- start = (op is compute) & ~busy & ~req.
- States:
  - IDLE: on an edge with start=1, latch the full result into a pending {phi,plo}, load cnt=LAT (MULT_CYCLES or DIV_CYCLES), set busy=1, go to BUSY.
  - BUSY: cnt decrements every edge. On the edge where cnt==1: commit hi<=phi, lo<=plo, set busy=0, go to IDLE.
- Timing: start sampled at edge E0 → busy high for exactly LAT cycles → HI/LO visible the cycle busy falls. Back-to-back launch is legal in that same cycle.
- mthi/mtlo: write hi<=a or lo<=a at the edge, only when ~busy & ~req. The stall unit guarantees no mt/mf op reaches E while busy or start is high. If one arrives anyway, it is ignored and HI/LO are unchanged.
- Compute ops presented while busy=1 are ignored; start=0 and no relaunch occurs.
- req does not abort an in-flight op. That op belongs to an older, already-committed instruction and always completes and commits.
- mult: signed 32x32→64. multu: unsigned. Result is {hi,lo}.
- div: signed, quotient truncated toward zero into lo; remainder into hi, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- divu: unsigned.
- Divide by zero: still busy for DIV_CYCLES, but HI/LO keep their prior values at commit.
- mduo is purely combinational from the current op and hi/lo. Reading during busy returns the old value (the stall unit prevents this case).

Optional Feature:
MDU_MADD_EN:
- Defined: ops 9-12 are compute ops with MULT_CYCLES latency.
  - madd/maddu: {hi,lo} + a*b (signed/unsigned product).
  - msub/msubu: {hi,lo} − a*b.
  - 64-bit wrap-around, no overflow flag.
  - The accumulate base is {hi,lo} sampled at the launch edge.
- Undefined: ops 9-12 behave as none (start=0, no state change).

Test Plan:
1. reset; op=1 (mult), a=0xFFFFFFFD, b=5 → start=1 for one cycle, busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy=0.
2. op=4 (divu), a=100, b=7 → busy for 10 cycles, then lo=14, hi=2. Then op=3 (div), a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. hi=0x11, lo=0x22; op=3, b=0 → busy for 10 cycles; hi=0x11, lo=0x22 unchanged. Then op=6 (mflo) → mduo=0x22.
4. op=1 with req=1 → start=0, busy stays 0, hi/lo unchanged. Also op=7 (mthi), a=0xABCD with req=1 → hi unchanged. Same op with req=0 → hi=0xABCD next cycle.
5. Launch mult; assert reset in the 3rd busy cycle → next cycle busy=0, hi=lo=0, and no commit follows. Launch mult at the commit cycle (back-to-back) → second result commits 5 cycles later.
6. (MDU_MADD_EN) hi=0, lo=0xFFFFFFFF; op=9 (madd), a=1, b=1 → after 5 cycles hi=1, lo=0. Without the macro, same stimulus → start=0, hi/lo unchanged.
